// File: rtl/spi_adc_pkg.sv
// -----------------------------------------------------------------------------
// spi_adc_pkg
// Shared definitions for the SPI ADC responder: FSM state encoding and the
// default frame geometry (12-bit sample preceded by 4 zero bits).
// -----------------------------------------------------------------------------
package spi_adc_pkg;

   localparam int DATA_W_DEF     = 12;
   localparam int LEAD_ZEROS_DEF = 4;
   localparam int FRAME_W_DEF    = LEAD_ZEROS_DEF + DATA_W_DEF;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

endpackage

// File: rtl/spi_adc_responder_if.sv
// -----------------------------------------------------------------------------
// spi_adc_responder_if
// SPI pin bundle between an initiator and the ADC responder.
//   sck     : SPI clock, idle low (mode 0), driven by the initiator
//   cs_n    : chip select, active low, driven by the initiator
//   mosi    : initiator -> responder data
//   miso    : responder -> initiator data
//   miso_oe : responder output enable for an external tri-state buffer
// -----------------------------------------------------------------------------
interface spi_adc_responder_if;

   logic sck;
   logic cs_n;
   logic mosi;
   logic miso;
   logic miso_oe;

   modport master (
      output sck,
      output cs_n,
      output mosi,
      input  miso,
      input  miso_oe
   );

   modport slave (
      input  sck,
      input  cs_n,
      input  mosi,
      output miso,
      output miso_oe
   );

endinterface

// File: rtl/spi_sync_edge.sv
// -----------------------------------------------------------------------------
// spi_sync_edge
// Multi-flop synchronizer for one asynchronous pin plus rise/fall detection
// on the synchronized value.
//   clk, reset : system clock, synchronous active-high reset
//   i_async    : asynchronous pin
//   o_sync     : synchronized level (SYNC_STAGES cycles late)
//   o_rise     : one-cycle pulse on a synchronized 0->1 transition
//   o_fall     : one-cycle pulse on a synchronized 1->0 transition
// RESET_VAL is the pin's idle level so that leaving reset creates no edge.
// -----------------------------------------------------------------------------
module spi_sync_edge #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RESET_VAL   = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic i_async,
   output logic o_sync,
   output logic o_rise,
   output logic o_fall
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;

   // NOTE: sequential state uses non-blocking assignments so every flop in the
   // chain samples the value from before this clock edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync <= {SYNC_STAGES{RESET_VAL}};
         r_prev <= RESET_VAL;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   assign o_sync = r_sync[SYNC_STAGES-1];
   assign o_rise =  r_sync[SYNC_STAGES-1] & ~r_prev;
   assign o_fall = ~r_sync[SYNC_STAGES-1] &  r_prev;

endmodule

// File: rtl/spi_adc_responder.sv
// -----------------------------------------------------------------------------
// spi_adc_responder
// Emulates a 12-bit serial ADC on a mode-0 SPI bus. All SPI pins are
// oversampled in the clk domain (clk must be >= 8x SCK).
//   clk, reset   : system clock, synchronous active-high reset
//   spi          : SPI pins (slave modport)
//   sample_in    : next sample value
//   sample_we    : loads sample_in into the holding register
//   sample_taken : pulse when the holding register is latched for a frame
//   rx_data      : last complete MOSI word, MSB first
//   rx_valid     : pulse when rx_data updates
//   frame_err    : pulse on a frame that ended with the wrong bit count
//   busy         : high while a frame is active
// -----------------------------------------------------------------------------
module spi_adc_responder
   import spi_adc_pkg::*;
#(
   parameter int  DATA_W      = DATA_W_DEF,
   parameter int  LEAD_ZEROS  = LEAD_ZEROS_DEF,
   parameter int  SYNC_STAGES = 2,
   localparam int FRAME_W     = LEAD_ZEROS + DATA_W
) (
   input  logic               clk,
   input  logic               reset,
   spi_adc_responder_if.slave spi,
   input  logic [DATA_W-1:0]  sample_in,
   input  logic               sample_we,
   output logic               sample_taken,
   output logic [FRAME_W-1:0] rx_data,
   output logic               rx_valid,
   output logic               frame_err,
   output logic               busy
);

   // Counter saturates at FRAME_W+1 so over-long frames stay distinguishable.
   localparam int           CNT_W   = $clog2(FRAME_W + 2);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_W + 1);

   // ---------------- pin synchronization ----------------
   logic w_sck_rise, w_sck_fall, w_sck_sync;
   logic w_cs_rise,  w_cs_fall,  w_cs_sync;
   logic [SYNC_STAGES-1:0] r_mosi_sync;

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
      .clk     (clk),
      .reset   (reset),
      .i_async (spi.sck),
      .o_sync  (w_sck_sync),
      .o_rise  (w_sck_rise),
      .o_fall  (w_sck_fall)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
      .clk     (clk),
      .reset   (reset),
      .i_async (spi.cs_n),
      .o_sync  (w_cs_sync),
      .o_rise  (w_cs_rise),
      .o_fall  (w_cs_fall)
   );

   // MOSI needs the same depth as SCK so the bit sampled on a detected SCK
   // rise is the one the initiator held around that pin edge.
   always_ff @(posedge clk) begin
      if (reset) r_mosi_sync <= '0;
      else       r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi.mosi};
   end

   // ---------------- FSM ----------------
   state_t r_state, w_state_nxt;
   logic   w_start, w_stop, w_shift_in, w_shift_out;

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   // NOTE: every output of this block gets a default first, so no path leaves
   // a signal unassigned and no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_stop      = 1'b0;
      w_shift_in  = 1'b0;
      w_shift_out = 1'b0;
      case (r_state)
         IDLE: begin
            // SCK edges are ignored while idle.
            if (w_cs_fall) begin
               w_state_nxt = ACTIVE;
               w_start     = 1'b1;
            end
         end
         ACTIVE: begin
            // A CS rise masks any SCK edge seen in the same cycle.
            if (w_cs_rise) begin
               w_state_nxt = IDLE;
               w_stop      = 1'b1;
            end else begin
               w_shift_in  = w_sck_rise;
               w_shift_out = w_sck_fall;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // ---------------- datapath ----------------
   logic [DATA_W-1:0]  r_hold;
   logic [FRAME_W-1:0] r_tx, r_rx, r_rx_data;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_miso, r_miso_oe;
   logic               r_rx_valid, r_frame_err, r_sample_taken;
   logic [FRAME_W-1:0] w_tx_load;

   assign w_tx_load = FRAME_W'(r_hold);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_hold         <= '0;
         r_tx           <= '0;
         r_rx           <= '0;
         r_rx_data      <= '0;
         r_cnt          <= '0;
         r_miso         <= 1'b0;
         r_miso_oe      <= 1'b0;
         r_rx_valid     <= 1'b0;
         r_frame_err    <= 1'b0;
         r_sample_taken <= 1'b0;
      end else begin
         r_rx_valid     <= 1'b0;
         r_frame_err    <= 1'b0;
         r_sample_taken <= 1'b0;

         // A write coinciding with frame start still loads the holding
         // register; the frame takes the value from before this edge.
         if (sample_we) r_hold <= sample_in;

         if (w_start) begin
            r_tx           <= w_tx_load;
            r_rx           <= '0;
            r_cnt          <= '0;
            r_miso         <= w_tx_load[FRAME_W-1];
            r_miso_oe      <= 1'b1;
            r_sample_taken <= 1'b1;
         end

         if (w_shift_in) begin
            r_rx <= {r_rx[FRAME_W-2:0], r_mosi_sync[SYNC_STAGES-1]};
            if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
         end

         // Zero fill makes MISO read 0 once the frame's bits are exhausted.
         if (w_shift_out) begin
            r_tx   <= {r_tx[FRAME_W-2:0], 1'b0};
            r_miso <= r_tx[FRAME_W-2];
         end

         if (w_stop) begin
            r_miso    <= 1'b0;
            r_miso_oe <= 1'b0;
            if (r_cnt == CNT_FULL) begin
               r_rx_data  <= r_rx;
               r_rx_valid <= 1'b1;
            end else begin
               r_frame_err <= 1'b1;
            end
         end
      end
   end

   assign spi.miso     = r_miso;
   assign spi.miso_oe  = r_miso_oe;
   assign sample_taken = r_sample_taken;
   assign rx_data      = r_rx_data;
   assign rx_valid     = r_rx_valid;
   assign frame_err    = r_frame_err;
   assign busy         = (r_state == ACTIVE);

   // Synchronized levels are kept for debug visibility only.
   logic w_unused;
   assign w_unused = w_sck_sync ^ w_cs_sync;

endmodule

// File: tb/tb_spi_adc_responder.sv
// -----------------------------------------------------------------------------
// tb_spi_adc_responder
// Directed bench: acts as a mode-0 SPI initiator at clk/10 and checks frame
// contents, pulse counts, latencies and reset behaviour of spi_adc_responder.
// -----------------------------------------------------------------------------
module tb_spi_adc_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic [11:0] sample_in;
   logic        sample_we;
   logic        sample_taken;
   logic [15:0] rx_data;
   logic        rx_valid;
   logic        frame_err;
   logic        busy;

   spi_adc_responder_if spi_bus ();

   spi_adc_responder dut (
      .clk          (clk),
      .reset        (reset),
      .spi          (spi_bus),
      .sample_in    (sample_in),
      .sample_we    (sample_we),
      .sample_taken (sample_taken),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .frame_err    (frame_err),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;

   // Cycle counter and pulse monitors, sampled on the falling clock edge.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_taken = 0, n_valid = 0, n_ferr = 0, last_pulse_cyc = 0;
   always @(negedge clk) begin
      if (sample_taken) n_taken++;
      if (rx_valid)  begin n_valid++; last_pulse_cyc = cyc; end
      if (frame_err) begin n_ferr++;  last_pulse_cyc = cyc; end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One SPI frame of nclk SCK clocks; MOSI sends word[nclk-1:0] MSB first.
   // we_at = bit index for a mid-frame sample write, -2 = write aligned with
   // the detected CS fall. rst_at = bit index at which reset is asserted.
   task automatic frame(input string tag, input int nclk, input logic [31:0] word,
                        input int we_at, input logic [11:0] we_val, input int rst_at,
                        output logic [31:0] rd);
      int c_rise;
      rd = '0;
      @(negedge clk);
      spi_bus.cs_n = 1'b0;
      spi_bus.mosi = word[nclk-1];
      @(negedge clk);
      @(negedge clk);
      if (we_at == -2) begin sample_in = we_val; sample_we = 1'b1; end
      check({tag, "/oe_lat_pre"}, {31'b0, spi_bus.miso_oe}, 32'd0);
      @(negedge clk);
      sample_we = 1'b0;
      check({tag, "/oe_lat"}, {31'b0, spi_bus.miso_oe}, 32'd1);
      check({tag, "/busy"},   {31'b0, busy},            32'd1);
      check({tag, "/taken"},  {31'b0, sample_taken},    32'd1);
      repeat (2) @(negedge clk);
      for (int i = 0; i < nclk; i++) begin
         if (i > 0) begin
            spi_bus.sck  = 1'b0;
            spi_bus.mosi = word[nclk-1-i];
            for (int j = 0; j < 5; j++) begin
               @(negedge clk);
               if (j == 0 && i == rst_at) begin
                  reset = 1'b1;
                  @(negedge clk);
                  check({tag, "/rst_oe"},    {31'b0, spi_bus.miso_oe}, 32'd0);
                  check({tag, "/rst_miso"},  {31'b0, spi_bus.miso},    32'd0);
                  check({tag, "/rst_busy"},  {31'b0, busy},            32'd0);
                  check({tag, "/rst_rx"},    {16'b0, rx_data},         32'd0);
                  check({tag, "/rst_valid"}, {31'b0, rx_valid},        32'd0);
                  check({tag, "/rst_ferr"},  {31'b0, frame_err},       32'd0);
                  check({tag, "/rst_taken"}, {31'b0, sample_taken},    32'd0);
                  spi_bus.cs_n = 1'b1;
                  repeat (4) @(negedge clk);
                  reset = 1'b0;
                  repeat (6) @(negedge clk);
                  return;
               end
               if (i == we_at) begin
                  if (j == 0) begin sample_in = we_val; sample_we = 1'b1; end
                  if (j == 1) sample_we = 1'b0;
               end
            end
         end
         spi_bus.sck = 1'b1;
         rd = {rd[30:0], spi_bus.miso};
         repeat (5) @(negedge clk);
      end
      spi_bus.sck = 1'b0;
      repeat (5) @(negedge clk);
      spi_bus.cs_n = 1'b1;
      c_rise = cyc;
      repeat (8) @(negedge clk);
      check({tag, "/end_lat"},  last_pulse_cyc - c_rise,   32'd3);
      check({tag, "/end_oe"},   {31'b0, spi_bus.miso_oe}, 32'd0);
      check({tag, "/end_miso"}, {31'b0, spi_bus.miso},    32'd0);
      check({tag, "/end_busy"}, {31'b0, busy},            32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      int s_t, s_v, s_f;

      reset        = 1'b1;
      spi_bus.cs_n = 1'b1;
      spi_bus.sck  = 1'b0;
      spi_bus.mosi = 1'b0;
      sample_in    = '0;
      sample_we    = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("reset/miso",  {31'b0, spi_bus.miso},    32'd0);
      check("reset/oe",    {31'b0, spi_bus.miso_oe}, 32'd0);
      check("reset/busy",  {31'b0, busy},            32'd0);
      check("reset/rx",    {16'b0, rx_data},         32'd0);
      check("reset/valid", {31'b0, rx_valid},        32'd0);
      check("reset/taken", {31'b0, sample_taken},    32'd0);
      check("reset/ferr",  {31'b0, frame_err},       32'd0);

      // Full frame: sample 0xA5C out, 0xC3F1 in.
      sample_in = 12'hA5C; sample_we = 1'b1;
      @(negedge clk); sample_we = 1'b0;
      s_t = n_taken; s_v = n_valid; s_f = n_ferr;
      frame("full", 16, 32'hC3F1, -1, 12'h0, -1, rd);
      check("full/miso",   rd,                32'h0A5C);
      check("full/rx",     {16'b0, rx_data},  32'hC3F1);
      check("full/ntaken", n_taken - s_t,     32'd1);
      check("full/nvalid", n_valid - s_v,     32'd1);
      check("full/nferr",  n_ferr - s_f,      32'd0);

      // Short frame: 9 clocks.
      s_v = n_valid; s_f = n_ferr;
      frame("short", 9, 32'h1FF, -1, 12'h0, -1, rd);
      check("short/miso",   rd,               32'h014);
      check("short/rx",     {16'b0, rx_data}, 32'hC3F1);
      check("short/nvalid", n_valid - s_v,    32'd0);
      check("short/nferr",  n_ferr - s_f,     32'd1);

      // Normal frame after the error.
      s_v = n_valid; s_f = n_ferr;
      frame("next", 16, 32'h1234, -1, 12'h0, -1, rd);
      check("next/miso",   rd,               32'h0A5C);
      check("next/rx",     {16'b0, rx_data}, 32'h1234);
      check("next/nvalid", n_valid - s_v,    32'd1);
      check("next/nferr",  n_ferr - s_f,     32'd0);

      // Over-long frame: 20 clocks, trailing bits read zero.
      s_v = n_valid; s_f = n_ferr;
      frame("long", 20, 32'hABCDE, -1, 12'h0, -1, rd);
      check("long/miso",   rd,               32'h0A5C0);
      check("long/rx",     {16'b0, rx_data}, 32'h1234);
      check("long/nvalid", n_valid - s_v,    32'd0);
      check("long/nferr",  n_ferr - s_f,     32'd1);

      // Write at bit 6 does not disturb the frame in flight.
      @(negedge clk); sample_in = 12'hFFF; sample_we = 1'b1;
      @(negedge clk); sample_we = 1'b0;
      frame("midwe", 16, 32'h0F0F, 6, 12'h123, -1, rd);
      check("midwe/miso", rd,               32'h0FFF);
      check("midwe/rx",   {16'b0, rx_data}, 32'h0F0F);
      frame("midwe2", 16, 32'h8001, -1, 12'h0, -1, rd);
      check("midwe2/miso", rd,               32'h0123);
      check("midwe2/rx",   {16'b0, rx_data}, 32'h8001);

      // Write in the same cycle as the detected CS fall.
      frame("cswe", 16, 32'h00FF, -2, 12'h456, -1, rd);
      check("cswe/miso", rd, 32'h0123);
      frame("cswe2", 16, 32'h5A5A, -1, 12'h0, -1, rd);
      check("cswe2/miso", rd,               32'h0456);
      check("cswe2/rx",   {16'b0, rx_data}, 32'h5A5A);

      // Reset at bit 8: no pulse reported, holding register cleared.
      s_v = n_valid; s_f = n_ferr;
      frame("rst", 16, 32'hFFFF, -1, 12'h0, 8, rd);
      check("rst/nvalid", n_valid - s_v, 32'd0);
      check("rst/nferr",  n_ferr - s_f,  32'd0);
      frame("after", 16, 32'h7E81, -1, 12'h0, -1, rd);
      check("after/miso", rd,               32'h0000);
      check("after/rx",   {16'b0, rx_data}, 32'h7E81);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/spi_adc_responder.md
# spi_adc_responder

SPI responder that emulates the 12-bit serial ADC read by the team's SPI state machine, so the initiator, LED test and display path can be exercised in simulation and loop-back on hardware. It answers frames on CS/SCK/MISO with a latched 12-bit sample and captures whatever the initiator sends on MOSI. All SPI inputs are oversampled in the `clk` domain; no logic is clocked by SCK.

## Interface
- `DATA_W`, 12: sample width in bits.
- `LEAD_ZEROS`, 4: zero bits sent before the sample MSB.
- `SYNC_STAGES`, 2: synchronizer depth on `sck`, `cs_n`, `mosi` (≥2).
- `clk` in 1: system clock. Required: `clk` frequency ≥ 8× SCK frequency.
- `reset` in 1: synchronous, active-high reset.
- `sck` in 1: SPI clock from initiator. Idle low (mode 0).
- `cs_n` in 1: chip select, active low.
- `mosi` in 1: initiator data.
- `miso` out 1: responder data.
- `miso_oe` out 1: high while a frame is active; external tri-state enable.
- `sample_in` in DATA_W: next sample value.
- `sample_we` in 1: write strobe; `sample_in` loaded into holding register.
- `sample_taken` out 1: one-cycle pulse when holding register is latched for a frame.
- `rx_data` out FRAME_W: last complete MOSI word, MSB first.
- `rx_valid` out 1: one-cycle pulse when `rx_data` updates.
- `frame_err` out 1: one-cycle pulse on an aborted or over-long frame.
- `busy` out 1: high in ACTIVE.

FRAME_W = LEAD_ZEROS + DATA_W (16 by default).

## Operation
- Inputs pass through SYNC_STAGES flops; edges detected from last two synchronized values of `sck` and `cs_n`.
- Holding register: loaded on any cycle with `sample_we`; writes during a frame do not disturb the frame in flight.
- States: IDLE, ACTIVE.
- IDLE → ACTIVE on synchronized `cs_n` falling edge: tx shift reg ← {LEAD_ZEROS'b0, holding}; bit counter ← 0; `miso` ← tx MSB; `miso_oe` ← 1; `sample_taken` pulses.
- ACTIVE, `sck` rising edge: shift synchronized `mosi` into rx shift reg LSB; bit counter increments, saturating at FRAME_W+1.
- ACTIVE, `sck` falling edge: tx reg shifts left, zero fill; `miso` ← new MSB. After FRAME_W bits `miso` stays 0.
- ACTIVE → IDLE on `cs_n` rising edge: `miso_oe` ← 0, `miso` ← 0. Count == FRAME_W: `rx_data` ← rx shift reg, `rx_valid` pulses. Otherwise: `rx_data` unchanged, `frame_err` pulses.
- `cs_n` rise and `sck` edge detected same cycle: CS rise wins, SCK edge ignored.
- `sample_we` same cycle as CS fall: old holding value goes to the frame, new value to holding.
- SCK edges in IDLE ignored.

## Timing
- Reset: state IDLE, `miso` 0, `miso_oe` 0, `busy` 0, `rx_data` 0, `rx_valid` 0, `sample_taken` 0, `frame_err` 0, holding 0, counter 0.
- Reset mid-frame: same values next cycle; the frame is not reported (no `frame_err`).
- Pin-to-response latency: SYNC_STAGES+1 `clk` cycles from `cs_n`/`sck` pin edge to `miso`/`miso_oe` update (3 by default).
- `miso` changes only after SCK falling edges or CS edges; it is stable at every SCK rising edge when the clock ratio is ≥ 8.
- `rx_valid`/`frame_err` assert SYNC_STAGES+1 cycles after the `cs_n` pin rises, width exactly 1 cycle.

## Structure
- Package `spi_adc_pkg`: state enum (IDLE, ACTIVE), default DATA_W, LEAD_ZEROS, FRAME_W.
- Sub-module `spi_sync_edge`: SYNC_STAGES-flop synchronizer with rise/fall pulses. Instantiated for `sck` and `cs_n`. `mosi` uses the synchronizer only.

## Test plan
- `sample_in`=0xA5C, `sample_we`; 16-clock frame at clk/10 → initiator reads 0x0A5C, `sample_taken` one pulse at CS fall, `frame_err` 0.
- MOSI drives 0xC3F1 during 16-clock frame → `rx_valid` one pulse after CS rise, `rx_data`=0xC3F1.
- CS raised after 9 SCK clocks → `frame_err` pulse, `rx_data` keeps prior value, `miso_oe` 0, next frame normal.
- 20 SCK clocks in one frame → bits 17–20 on `miso` read 0, `frame_err` pulse, no `rx_valid`.
- `sample_we` with 0x123 at bit 6 of a frame carrying 0xFFF → frame reads 0x0FFF, next frame reads 0x0123.
- `reset` asserted at bit 8 → next cycle all outputs at reset values, no pulse; subsequent frame returns 0x0000.
